ram_responder: RTL

- Single-port word RAM slave that answers the CPU core's readReq/writeReq pulse handshake with readAck/writeAck pulses after a programmable latency.
- Sits between the core's ramAddress/ramOut/ramIn bus and on-chip storage.
- Provides a backdoor load port for program/data preload, plus sticky error flags for protocol and range violations.

---
 rtl/ram_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ram_responder.sv
// ram_responder: single-port word RAM slave for the core's readReq/writeReq
// pulse handshake. Each accepted request is answered by a one-cycle ack after
// a fixed latency. A backdoor port preloads the array while the responder is
// idle. Sticky flags report protocol misuse and addresses beyond the array.
module ram_responder #(
    parameter int ADDR_BITS     = 10,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ramAddress,
    input  logic [31:0] ramOut,
    input  logic        readReq,
    input  logic        writeReq,
    output logic [31:0] ramIn,
    output logic        readAck,
    output logic        writeAck,
    input  logic        loadEn,
    input  logic [31:0] loadAddr,
    input  logic [31:0] loadData,
    output logic        busy,
    output logic        protoErr,
    output logic        rangeErr
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    // The counter is loaded with latency-1 so the ack lands exactly
    // LATENCY edges after the request was sampled.
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    logic [31:0] mem [0:(1 << ADDR_BITS) - 1];

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            ramIn_q, ramIn_d;
    logic                   readAck_q, readAck_d;
    logic                   writeAck_q, writeAck_d;
    logic                   protoErr_q, protoErr_d;
    logic                   rangeErr_q, rangeErr_d;

    logic                   memWe;
    logic [ADDR_BITS-1:0]   memWaddr;
    logic [31:0]            memWdata;

    logic [ADDR_BITS-1:0]   reqIdx, loadIdx;
    logic                   reqOutOfRange, loadOutOfRange;
    logic                   unusedLowBits;

    // Byte addresses become word indices; bits above the array set rangeErr
    // while the access wraps onto the truncated index.
    assign reqIdx         = ramAddress[ADDR_BITS+1:2];
    assign loadIdx        = loadAddr[ADDR_BITS+1:2];
    assign reqOutOfRange  = |(ramAddress >> (ADDR_BITS + 2));
    assign loadOutOfRange = |(loadAddr >> (ADDR_BITS + 2));
    assign unusedLowBits  = ^{ramAddress[1:0], loadAddr[1:0]};

    // Next-state logic: request capture in IDLE, latency countdown and
    // completion in the wait states, protocol/range error detection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        ramIn_d    = ramIn_q;
        readAck_d  = 1'b0;
        writeAck_d = 1'b0;
        protoErr_d = protoErr_q;
        rangeErr_d = rangeErr_q;
        memWe      = 1'b0;
        memWaddr   = idx_q;
        memWdata   = wdata_q;
        case (state_q)
            IDLE: begin
                if (readReq || writeReq) begin
                    idx_d = reqIdx;
                    if (reqOutOfRange) rangeErr_d = 1'b1;
                    if (loadEn) protoErr_d = 1'b1;
                    if (readReq) begin
                        cnt_d   = RD_LOAD;
                        state_d = RD_WAIT;
                        if (writeReq) protoErr_d = 1'b1;
                    end else begin
                        cnt_d   = WR_LOAD;
                        wdata_d = ramOut;
                        state_d = WR_WAIT;
                    end
                end else if (loadEn) begin
                    memWe    = 1'b1;
                    memWaddr = loadIdx;
                    memWdata = loadData;
                    if (loadOutOfRange) rangeErr_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    ramIn_d   = mem[idx_q];
                    readAck_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (readReq || writeReq) protoErr_d = 1'b1;
                end
                if (loadEn) protoErr_d = 1'b1;
            end
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    memWe      = 1'b1;
                    writeAck_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (readReq || writeReq) protoErr_d = 1'b1;
                end
                if (loadEn) protoErr_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            ramIn_q    <= 32'd0;
            readAck_q  <= 1'b0;
            writeAck_q <= 1'b0;
            protoErr_q <= 1'b0;
            rangeErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            ramIn_q    <= ramIn_d;
            readAck_q  <= readAck_d;
            writeAck_q <= writeAck_d;
            protoErr_q <= protoErr_d;
            rangeErr_q <= rangeErr_d;
        end
    end

    // Storage array has a single write port shared by commits and backdoor loads.
    always_ff @(posedge clk) begin
        if (memWe) mem[memWaddr] <= memWdata;
    end

    assign ramIn    = ramIn_q;
    assign readAck  = readAck_q;
    assign writeAck = writeAck_q;
    assign busy     = (state_q != IDLE);
    assign protoErr = protoErr_q;
    assign rangeErr = rangeErr_q;

endmodule
